// File: rtl/elm_mac_pe.sv
// Processing element for the spiral NN array. It has a signed multiply-accumulate unit with a wide
// wrapping accumulator, a local DMEM and a CMEM micro-program. An FSM steps through the program,
// with a repeat count and stalls while operands are not valid. The horizontal and vertical
// operand streams are forwarded to neighbours one cycle later, whatever the FSM is doing.
module elm_mac_pe #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned AccWidth  = 20,
    parameter int unsigned AddrDMEM  = 4,
    parameter int unsigned AddrCMEM  = 4,
    parameter int unsigned RepWidth  = 4,
    parameter int unsigned ConfWidth = AddrDMEM + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrCMEM:0]    prog_len,
    input  logic [RepWidth-1:0]  prog_rep,
    output logic                 busy,
    output logic                 done,
    input  logic                 cfg_we,
    input  logic [AddrCMEM-1:0]  cfg_addr,
    input  logic [ConfWidth-1:0] cfg_wdata,
    input  logic                 dm_we,
    input  logic [AddrDMEM-1:0]  dm_addr,
    input  logic [DataWidth-1:0] dm_wdata,
    input  logic [DataWidth-1:0] h_s_i,
    input  logic                 h_v_i,
    input  logic [DataWidth-1:0] v_s_i,
    input  logic                 v_v_i,
    output logic [DataWidth-1:0] h_s_o,
    output logic                 h_v_o,
    output logic [DataWidth-1:0] v_s_o,
    output logic                 v_v_o,
    output logic [DataWidth-1:0] res_o,
    output logic                 res_v,
    output logic                 sat_o
);

    localparam int unsigned PcW       = AddrCMEM + 1;
    localparam int unsigned DmemDepth = 2 ** AddrDMEM;
    localparam int unsigned CmemDepth = 2 ** AddrCMEM;
    localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] SatMin = ~SatMax;

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpMac   = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;
    localparam logic [1:0] OpOut   = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                     state_q, state_d;
    logic [PcW-1:0]             pc_q, pc_d;
    logic [PcW-1:0]             len_q, len_d;
    logic [RepWidth-1:0]        rep_q, rep_d;
    logic [RepWidth-1:0]        rep_max_q, rep_max_d;
    logic signed [AccWidth-1:0] acc_q, acc_d;
    logic [DataWidth-1:0]       res_q, res_d;
    logic                       res_v_q, res_v_d;
    logic                       sat_q, sat_d;
    logic [DataWidth-1:0]       h_s_q, v_s_q;
    logic                       h_v_q, v_v_q;

    logic [DataWidth-1:0] dmem_q [DmemDepth];
    logic [ConfWidth-1:0] cmem_q [CmemDepth];

    logic                  dm_wr_en;
    logic [AddrDMEM-1:0]   dm_wr_addr;
    logic [DataWidth-1:0]  dm_wr_data;

    // Instruction decode: {op, src, clr, addr}
    logic [ConfWidth-1:0]        instr;
    logic [1:0]                  ins_op;
    logic                        ins_src;
    logic                        ins_clr;
    logic [AddrDMEM-1:0]         ins_addr;
    logic signed [DataWidth-1:0] opnd_b;
    logic signed [2*DataWidth-1:0] prod;
    logic signed [AccWidth-1:0]  prod_ext;
    logic [DataWidth-1:0]        sat_val;
    logic                        sat_hit;
    logic                        stall;
    logic                        is_last;

    // Operand selection, product, saturation and stall detection
    always_comb begin
        instr    = cmem_q[pc_q[AddrCMEM-1:0]];
        ins_op   = instr[ConfWidth-1 -: 2];
        ins_src  = instr[AddrDMEM+1];
        ins_clr  = instr[AddrDMEM];
        ins_addr = instr[AddrDMEM-1:0];
        opnd_b   = ins_src ? $signed(dmem_q[ins_addr]) : $signed(v_s_i);
        prod     = $signed(h_s_i) * opnd_b;
        prod_ext = AccWidth'(prod);
        sat_hit  = 1'b0;
        if (acc_q > SatMax) begin
            sat_val = SatMax[DataWidth-1:0];
            sat_hit = 1'b1;
        end else if (acc_q < SatMin) begin
            sat_val = SatMin[DataWidth-1:0];
            sat_hit = 1'b1;
        end else begin
            sat_val = acc_q[DataWidth-1:0];
        end
        // Only a MAC waits for operands; a DMEM-sourced MAC ignores the vertical valid
        stall   = (ins_op == OpMac) && (!h_v_i || (!ins_src && !v_v_i));
        is_last = (pc_q == len_q - PcW'(1));
    end

    // FSM next-state, program sequencing and datapath updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        rep_d      = rep_q;
        rep_max_d  = rep_max_q;
        acc_d      = acc_q;
        res_d      = res_q;
        res_v_d    = 1'b0;
        sat_d      = sat_q;
        dm_wr_en   = 1'b0;
        dm_wr_addr = dm_addr;
        dm_wr_data = dm_wdata;
        unique case (state_q)
            StIdle: begin
                dm_wr_en = dm_we;
                if (start) begin
                    pc_d      = '0;
                    rep_d     = RepWidth'(1);
                    len_d     = prog_len;
                    rep_max_d = (prog_rep == '0) ? RepWidth'(1) : prog_rep;
                    sat_d     = 1'b0;
                    state_d   = (prog_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!stall) begin
                    unique case (ins_op)
                        OpNop: ;
                        OpMac: acc_d = ins_clr ? prod_ext : acc_q + prod_ext;
                        OpStore: begin
                            dm_wr_en   = 1'b1;
                            dm_wr_addr = ins_addr;
                            dm_wr_data = sat_val;
                            sat_d      = sat_q | sat_hit;
                        end
                        OpOut: begin
                            res_d   = sat_val;
                            res_v_d = 1'b1;
                            sat_d   = sat_q | sat_hit;
                        end
                        default: ;
                    endcase
                    if (is_last) begin
                        if (rep_q < rep_max_q) begin
                            pc_d  = '0;
                            rep_d = rep_q + RepWidth'(1);
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        pc_d = pc_q + PcW'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control, accumulator, result and forwarding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            rep_max_q <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_v_q   <= 1'b0;
            sat_q     <= 1'b0;
            h_s_q     <= '0;
            h_v_q     <= 1'b0;
            v_s_q     <= '0;
            v_v_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            rep_max_q <= rep_max_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_v_q   <= res_v_d;
            sat_q     <= sat_d;
            h_s_q     <= h_s_i;
            h_v_q     <= h_v_i;
            v_s_q     <= v_s_i;
            v_v_q     <= v_v_i;
        end
    end

    // Memories are not reset; writes from outside are taken only while idle
    always_ff @(posedge clk) begin
        if (dm_wr_en) begin
            dmem_q[dm_wr_addr] <= dm_wr_data;
        end
        if (cfg_we && state_q == StIdle) begin
            cmem_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign res_o = res_q;
    assign res_v = res_v_q;
    assign sat_o = sat_q;
    assign h_s_o = h_s_q;
    assign h_v_o = h_v_q;
    assign v_s_o = v_s_q;
    assign v_v_o = v_v_q;

endmodule
